// File: rtl/config_loader.sv
// config_loader: byte-serial configuration bitstream loader for the tile array.
//   Collects 8-byte {addr, data} records over a valid/ready byte handshake and
//   issues each normal record as a one-cycle write on config_addr/config_data.
//   A record whose addr equals END_ADDR terminates the load and carries the
//   XOR checksum of all data words written in this load.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 begin a load (honoured in IDLE or DONE)
//   byte_in/byte_valid    bitstream byte and its valid
//   byte_ready            loader accepts byte_in this cycle
//   config_addr/data      write bus, held between writes
//   config_valid          one-cycle write strobe
//   word_count            records written this load (saturating)
//   load_done, cfg_error  terminator seen / checksum mismatch at terminator
module config_loader #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_valid,
    output logic [15:0] word_count,
    output logic        load_done,
    output logic        cfg_error
);

    localparam int unsigned ST_W   = 3;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned REC_W  = 64;

    localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] S_COLLECT = 3'd1;
    localparam logic [ST_W-1:0] S_ISSUE   = 3'd2;
    localparam logic [ST_W-1:0] S_HOLD    = 3'd3;
    localparam logic [ST_W-1:0] S_DONE    = 3'd4;

    logic [ST_W-1:0]   state_q,        state_d;
    logic [REC_W-1:0]  rec_q,          rec_d;
    logic [2:0]        byte_cnt_q,     byte_cnt_d;
    logic [31:0]       checksum_q,     checksum_d;
    logic [HOLD_W-1:0] hold_cnt_q,     hold_cnt_d;
    logic [15:0]       word_count_q,   word_count_d;
    logic              load_done_q,    load_done_d;
    logic              cfg_error_q,    cfg_error_d;
    logic [31:0]       config_addr_q,  config_addr_d;
    logic [31:0]       config_data_q,  config_data_d;
    logic              config_valid_q, config_valid_d;
    logic              byte_ready_q,   byte_ready_d;

    logic              xfer;
    logic [REC_W-1:0]  next_rec;

    // Bytes shift in from the top so byte 0 ends up in rec[7:0]:
    // rec[31:0] is addr, rec[63:32] is data, both LSB first.
    assign xfer     = byte_valid & byte_ready_q;
    assign next_rec = {byte_in, rec_q[REC_W-1:8]};

    // Next-state and datapath update
    always_comb begin
        state_d        = state_q;
        rec_d          = rec_q;
        byte_cnt_d     = byte_cnt_q;
        checksum_d     = checksum_q;
        hold_cnt_d     = hold_cnt_q;
        word_count_d   = word_count_q;
        load_done_d    = load_done_q;
        cfg_error_d    = cfg_error_q;
        config_addr_d  = config_addr_q;
        config_data_d  = config_data_q;
        config_valid_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    checksum_d   = '0;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                    cfg_error_d  = 1'b0;
                    byte_cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    rec_d      = next_rec;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        state_d = S_ISSUE;
                        // Launch the write on the byte-7 edge so the strobe
                        // is high exactly during the ISSUE cycle.
                        if (next_rec[31:0] != END_ADDR) begin
                            config_addr_d  = next_rec[31:0];
                            config_data_d  = next_rec[63:32];
                            config_valid_d = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (rec_q[31:0] == END_ADDR) begin
                    load_done_d = 1'b1;
                    cfg_error_d = (rec_q[63:32] != checksum_q);
                    state_d     = S_DONE;
                end else begin
                    checksum_d = checksum_q ^ rec_q[63:32];
                    if (word_count_q != 16'hFFFF) begin
                        word_count_d = word_count_q + 16'd1;
                    end
                    if (HOLD_CYCLES == 0) begin
                        state_d = S_COLLECT;
                    end else begin
                        state_d    = S_HOLD;
                        hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_COLLECT;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_COLLECT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rec_q          <= '0;
            byte_cnt_q     <= '0;
            checksum_q     <= '0;
            hold_cnt_q     <= '0;
            word_count_q   <= '0;
            load_done_q    <= 1'b0;
            cfg_error_q    <= 1'b0;
            config_addr_q  <= '0;
            config_data_q  <= '0;
            config_valid_q <= 1'b0;
            byte_ready_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rec_q          <= rec_d;
            byte_cnt_q     <= byte_cnt_d;
            checksum_q     <= checksum_d;
            hold_cnt_q     <= hold_cnt_d;
            word_count_q   <= word_count_d;
            load_done_q    <= load_done_d;
            cfg_error_q    <= cfg_error_d;
            config_addr_q  <= config_addr_d;
            config_data_q  <= config_data_d;
            config_valid_q <= config_valid_d;
            byte_ready_q   <= byte_ready_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign config_addr  = config_addr_q;
    assign config_data  = config_data_q;
    assign config_valid = config_valid_q;
    assign word_count   = word_count_q;
    assign load_done    = load_done_q;
    assign cfg_error    = cfg_error_q;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: randomized scoreboard bench for config_loader.
//   The driver computes expected writes and load results from the record
//   list before streaming it; a negedge monitor pops and compares.
module tb_config_loader;

    localparam int unsigned TB_HOLD = 3;
    localparam logic [31:0] TB_END  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_valid;
    logic [15:0] word_count;
    logic        load_done;
    logic        cfg_error;

    config_loader #(.HOLD_CYCLES(TB_HOLD), .END_ADDR(TB_END)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_valid (config_valid),
        .word_count   (word_count),
        .load_done    (load_done),
        .cfg_error    (cfg_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] exp_wr[$];     // {data, addr}
    logic [16:0] exp_done[$];   // {cfg_error, word_count}
    logic [63:0] recs[$];       // stimulus records {data, addr}
    int          wr_times[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: write scoreboard, bus stability, load completion
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
            prev_done = 1'b0;
        end else begin
            if (config_valid === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {config_data, config_addr}, 64'h0);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    chk("write_addr", 64'(config_addr), 64'(e[31:0]));
                    chk("write_data", 64'(config_data), 64'(e[63:32]));
                end
                last_addr = config_addr;
                last_data = config_data;
                wr_times.push_back(cyc);
            end else begin
                chk("bus_hold", {config_data, config_addr}, {last_data, last_addr});
            end
            if (load_done === 1'b1 && !prev_done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'(load_done), 64'h0);
                end else begin
                    logic [16:0] d;
                    d = exp_done.pop_front();
                    chk("done_word_count", 64'(word_count), 64'(d[15:0]));
                    chk("done_cfg_error", 64'(cfg_error), 64'(d[16]));
                end
            end
            prev_done = load_done;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        byte_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte until accepted; gap = negedges spent waiting for ready.
    task automatic send_byte(input logic [7:0] b, output int gap);
        int n;
        n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("byte_ready_timeout", 64'(n), 64'h0);
        @(negedge clk);
        gap = n;
    endtask

    // Stream recs as one load; expectations come from the record list alone.
    task automatic run_load(input bit tied, input bit bubbles, input bit pulse_mid);
        logic [31:0] xs;
        int unsigned cnt;
        int          nrec;
        int          gap;
        int          w;
        xs = '0;
        cnt = 0;
        nrec = 0;
        foreach (recs[k]) begin
            nrec++;
            if (recs[k][31:0] == TB_END) begin
                exp_done.push_back({recs[k][63:32] != xs, 16'(cnt)});
                break;
            end
            exp_wr.push_back(recs[k]);
            xs ^= recs[k][63:32];
            if (cnt < 65535) cnt++;
        end
        pulse_start();
        chk("ready_after_start", 64'(byte_ready), 64'h1);
        for (int k = 0; k < nrec; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (bubbles && $urandom_range(0, 3) == 0) begin
                    byte_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        start = pulse_mid && ($urandom_range(0, 1) == 1);
                        @(negedge clk);
                    end
                    start = 1'b0;
                end
                send_byte(recs[k][8*b +: 8], gap);
                if (tied && !bubbles && b == 0 && k > 0)
                    chk("ready_gap", 64'(gap), 64'(TB_HOLD + 1));
            end
        end
        byte_valid = 1'b0;
        w = 0;
        while (load_done !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("done_timeout", 64'(w), 64'h0);
        @(negedge clk);
        chk("drained", 64'(exp_wr.size() + exp_done.size()), 64'h0);
        chk("ready_in_done", 64'(byte_ready), 64'h0);
    endtask

    function automatic logic [63:0] rand_rec();
        logic [31:0] a;
        a = $urandom;
        if (a == TB_END) a = 32'h0000_0001;
        return {32'($urandom), a};
    endfunction

    initial begin
        int gap;
        logic [31:0] xs;
        int n;

        // Reset state
        do_reset();
        chk("rst_byte_ready", 64'(byte_ready), 64'h0);
        chk("rst_config_valid", 64'(config_valid), 64'h0);
        chk("rst_config_addr", 64'(config_addr), 64'h0);
        chk("rst_config_data", 64'(config_data), 64'h0);
        chk("rst_word_count", 64'(word_count), 64'h0);
        chk("rst_load_done", 64'(load_done), 64'h0);
        chk("rst_cfg_error", 64'(cfg_error), 64'h0);
        // byte_valid in IDLE must not be consumed
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", 64'(byte_ready), 64'h0);
        byte_valid = 1'b0;

        // Directed record plus matching terminator
        recs = {64'hDEADBEEF_00020001, 64'hDEADBEEF_FFFFFFFF};
        run_load(1'b0, 1'b0, 1'b0);
        chk("term_addr_kept", 64'(config_addr), 64'h0002_0001);
        chk("term_data_kept", 64'(config_data), 64'hDEAD_BEEF);

        // Same with bad checksum, restarted from DONE
        recs = {64'hDEADBEEF_00020001, 64'h00000000_FFFFFFFF};
        run_load(1'b0, 1'b0, 1'b0);
        chk("bad_cksum_err", 64'(cfg_error), 64'h1);

        // byte_valid tied high: ready gaps and write period
        recs.delete();
        xs = '0;
        for (int k = 0; k < 3; k++) begin
            recs.push_back(rand_rec());
            xs ^= recs[k][63:32];
        end
        recs.push_back({xs, TB_END});
        wr_times.delete();
        run_load(1'b1, 1'b0, 1'b0);
        chk("period_count", 64'(wr_times.size()), 64'd3);
        if (wr_times.size() == 3) begin
            chk("period_1", 64'(wr_times[1] - wr_times[0]), 64'(9 + TB_HOLD - 1 + 1));
            chk("period_2", 64'(wr_times[2] - wr_times[1]), 64'(8 + 1 + TB_HOLD));
        end

        // Reset after 5 bytes of a record discards it
        pulse_start();
        for (int b = 0; b < 5; b++) send_byte(8'h10 + 8'(b), gap);
        byte_valid = 1'b0;
        do_reset();
        chk("midrst_word_count", 64'(word_count), 64'h0);
        chk("midrst_addr", 64'(config_addr), 64'h0);
        recs = {64'h12345678_00070003, 64'h12345678_FFFFFFFF};
        run_load(1'b0, 1'b0, 1'b0);

        // From DONE: two records, bubbles, start pulsed mid-collect
        recs = {64'h0000FFFF_00010001, 64'hA5A50000_00020002, 64'hA5A5FFFF_FFFFFFFF};
        run_load(1'b0, 1'b1, 1'b1);
        chk("two_rec_count", 64'(word_count), 64'd2);

        // Terminator as first record
        recs = {64'h00000000_FFFFFFFF};
        run_load(1'b0, 1'b0, 1'b0);
        recs = {64'h00000040_FFFFFFFF};
        run_load(1'b0, 1'b0, 1'b0);

        // Randomized loads
        for (int t = 0; t < 8; t++) begin
            recs.delete();
            xs = '0;
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                recs.push_back(rand_rec());
                xs ^= recs[k][63:32];
            end
            recs.push_back({($urandom_range(0, 1) == 1) ? xs : 32'($urandom), TB_END});
            run_load($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
